// File: rtl/activation_reuse_buffer.sv
// Two-entry activation buffer: each accepted word is presented to the PE array
// reuse_count times (0 treated as 1) before it is popped.
module activation_reuse_buffer #(
  parameter int unsigned IO_DATA_WIDTH = 8,
  parameter int unsigned MEM_BW        = 128,
  parameter int unsigned CNT_WIDTH     = 8
) (
  input  logic                                              clk,
  input  logic                                              arst_n_in,
  input  logic [(MEM_BW/IO_DATA_WIDTH)*IO_DATA_WIDTH-1:0]   act_in,
  input  logic                                              act_in_valid,
  output logic                                              act_in_ready,
  input  logic [CNT_WIDTH-1:0]                              reuse_count,
  input  logic                                              flush,
  output logic [(MEM_BW/IO_DATA_WIDTH)*IO_DATA_WIDTH-1:0]   act_out,
  output logic                                              act_out_valid,
  input  logic                                              act_out_ready,
  output logic                                              act_out_last,
  output logic [1:0]                                        occupancy
);

  localparam int unsigned LANES = MEM_BW / IO_DATA_WIDTH;
  localparam int unsigned DW    = LANES * IO_DATA_WIDTH;

  logic [DW-1:0]        data_q  [2];
  logic [CNT_WIDTH-1:0] reuse_q [2];
  logic                 wr_ptr_q, wr_ptr_d;
  logic                 rd_ptr_q, rd_ptr_d;
  logic [1:0]           occ_q, occ_d;
  logic [CNT_WIDTH-1:0] use_q, use_d;

  logic                 push, adv, pop;
  logic [CNT_WIDTH-1:0] reuse_wr;
  logic [CNT_WIDTH-1:0] head_reuse;

  // Outputs depend only on registered state.
  always_comb begin
    head_reuse    = reuse_q[rd_ptr_q];
    act_out_valid = (occ_q != 2'd0);
    act_out       = act_out_valid ? data_q[rd_ptr_q] : '0;
    act_out_last  = act_out_valid && (use_q == CNT_WIDTH'(head_reuse - CNT_WIDTH'(1)));
    act_in_ready  = (occ_q != 2'd2);
    occupancy     = occ_q;
  end

  // Next-state for pointers, occupancy and the per-word presentation counter.
  always_comb begin
    push     = act_in_valid && act_in_ready && !flush;
    adv      = act_out_valid && act_out_ready && !flush;
    pop      = adv && act_out_last;
    reuse_wr = (reuse_count == '0) ? CNT_WIDTH'(1) : reuse_count;

    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    occ_d    = occ_q;
    use_d    = use_q;

    if (push) wr_ptr_d = ~wr_ptr_q;
    if (pop)  rd_ptr_d = ~rd_ptr_q;

    if (push && !pop)      occ_d = 2'(occ_q + 2'd1);
    else if (pop && !push) occ_d = 2'(occ_q - 2'd1);

    if (adv) use_d = pop ? '0 : CNT_WIDTH'(use_q + CNT_WIDTH'(1));

    if (flush) begin
      wr_ptr_d = 1'b0;
      rd_ptr_d = 1'b0;
      occ_d    = 2'd0;
      use_d    = '0;
    end
  end

  always_ff @(posedge clk or negedge arst_n_in) begin
    if (!arst_n_in) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      occ_q    <= 2'd0;
      use_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
      use_q    <= use_d;
    end
  end

  // Payload storage needs no reset: it is only observed when occupancy > 0.
  always_ff @(posedge clk) begin
    if (push) begin
      data_q[wr_ptr_q]  <= act_in;
      reuse_q[wr_ptr_q] <= reuse_wr;
    end
  end

endmodule

// File: tb/tb_activation_reuse_buffer.sv
// Directed self-checking bench for activation_reuse_buffer.
module tb_activation_reuse_buffer;

  localparam int unsigned DW = 128;

  logic          clk = 1'b0;
  logic          arst_n_in;
  logic [DW-1:0] act_in;
  logic          act_in_valid;
  logic          act_in_ready;
  logic [7:0]    reuse_count;
  logic          flush;
  logic [DW-1:0] act_out;
  logic          act_out_valid;
  logic          act_out_ready;
  logic          act_out_last;
  logic [1:0]    occupancy;

  int checks = 0;
  int errors = 0;

  localparam logic [DW-1:0] W0 = 128'h0F0E0D0C0B0A09080706050403020100;
  localparam logic [DW-1:0] WA = 128'hA5A5A5A5_A5A5A5A5_A5A5A5A5_A5A5A5A5;
  localparam logic [DW-1:0] WB = 128'h3C3C3C3C_11223344_55667788_99AABBCC;
  localparam logic [DW-1:0] WC = 128'hDEADBEEF_00000000_FFFFFFFF_12345678;
  localparam logic [DW-1:0] WD = 128'h0123456789ABCDEF_FEDCBA9876543210;
  localparam logic [DW-1:0] WE = 128'h5A5A5A5A_5A5A5A5A_C3C3C3C3_C3C3C3C3;

  activation_reuse_buffer #(.IO_DATA_WIDTH(8), .MEM_BW(128), .CNT_WIDTH(8)) dut (
    .clk           (clk),
    .arst_n_in     (arst_n_in),
    .act_in        (act_in),
    .act_in_valid  (act_in_valid),
    .act_in_ready  (act_in_ready),
    .reuse_count   (reuse_count),
    .flush         (flush),
    .act_out       (act_out),
    .act_out_valid (act_out_valid),
    .act_out_ready (act_out_ready),
    .act_out_last  (act_out_last),
    .occupancy     (occupancy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Full output snapshot against expected values.
  task automatic chk_out(input string tag, input logic v, input logic [DW-1:0] d,
                         input logic l, input logic [1:0] occ, input logic rdy);
    chk({tag, ".valid"}, DW'(act_out_valid), DW'(v));
    chk({tag, ".data"},  act_out, d);
    chk({tag, ".last"},  DW'(act_out_last), DW'(l));
    chk({tag, ".occ"},   DW'(occupancy), DW'(occ));
    chk({tag, ".in_rdy"}, DW'(act_in_ready), DW'(rdy));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_set(input logic [DW-1:0] d, input logic [7:0] r);
    act_in       = d;
    reuse_count  = r;
    act_in_valid = 1'b1;
  endtask

  initial begin
    arst_n_in     = 1'b0;
    act_in        = '0;
    act_in_valid  = 1'b0;
    reuse_count   = 8'd0;
    flush         = 1'b0;
    act_out_ready = 1'b0;
    #2;
    chk_out("reset", 1'b0, '0, 1'b0, 2'd0, 1'b1);
    tick();
    tick();
    arst_n_in = 1'b1;
    tick();

    // Single word, reuse 1.
    push_set(W0, 8'd1);
    act_out_ready = 1'b1;
    tick();
    act_in_valid = 1'b0;
    chk_out("w0_present", 1'b1, W0, 1'b1, 2'd1, 1'b1);
    tick();
    chk_out("w0_popped", 1'b0, '0, 1'b0, 2'd0, 1'b1);

    // A reuse 3, B reuse 2, fill then drain.
    act_out_ready = 1'b0;
    push_set(WA, 8'd3);
    tick();
    chk_out("a_loaded", 1'b1, WA, 1'b0, 2'd1, 1'b1);
    push_set(WB, 8'd2);
    tick();
    act_in_valid  = 1'b0;
    act_out_ready = 1'b1;
    chk_out("ab_full_u0", 1'b1, WA, 1'b0, 2'd2, 1'b0);
    tick();
    chk_out("a_u1", 1'b1, WA, 1'b0, 2'd2, 1'b0);
    tick();
    chk_out("a_u2_last", 1'b1, WA, 1'b1, 2'd2, 1'b0);
    tick();
    chk_out("b_u0", 1'b1, WB, 1'b0, 2'd1, 1'b1);
    tick();
    chk_out("b_u1_last", 1'b1, WB, 1'b1, 2'd1, 1'b1);
    tick();
    chk_out("ab_drained", 1'b0, '0, 1'b0, 2'd0, 1'b1);

    // Stall with both entries full.
    act_out_ready = 1'b0;
    push_set(WA, 8'd1);
    tick();
    push_set(WB, 8'd1);
    tick();
    push_set(WC, 8'd1);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk_out($sformatf("stall%0d", i), 1'b1, WA, 1'b1, 2'd2, 1'b0);
    end
    act_in_valid  = 1'b0;
    act_out_ready = 1'b1;
    tick();
    chk_out("stall_rel_b", 1'b1, WB, 1'b1, 2'd1, 1'b1);
    tick();
    chk_out("stall_empty", 1'b0, '0, 1'b0, 2'd0, 1'b1);

    // reuse_count 0 behaves as 1.
    push_set(WC, 8'd0);
    tick();
    act_in_valid = 1'b0;
    chk_out("r0_present", 1'b1, WC, 1'b1, 2'd1, 1'b1);
    tick();
    chk_out("r0_popped", 1'b0, '0, 1'b0, 2'd0, 1'b1);

    // Flush at occupancy 2, use counter 1, with a push attempted.
    act_out_ready = 1'b0;
    push_set(WA, 8'd3);
    tick();
    push_set(WB, 8'd2);
    tick();
    act_in_valid  = 1'b0;
    act_out_ready = 1'b1;
    tick();
    chk_out("pre_flush_u1", 1'b1, WA, 1'b0, 2'd2, 1'b0);
    flush = 1'b1;
    push_set(WD, 8'd1);
    tick();
    flush        = 1'b0;
    act_in_valid = 1'b0;
    chk_out("flushed", 1'b0, '0, 1'b0, 2'd0, 1'b1);
    tick();
    chk_out("flush_push_lost", 1'b0, '0, 1'b0, 2'd0, 1'b1);

    // Flush while a push is accepted at occupancy 0 discards it.
    flush = 1'b1;
    push_set(WD, 8'd1);
    tick();
    flush        = 1'b0;
    act_in_valid = 1'b0;
    chk_out("flush_empty_push", 1'b0, '0, 1'b0, 2'd0, 1'b1);

    // Async reset mid-reuse with occupancy 2.
    act_out_ready = 1'b0;
    push_set(WA, 8'd3);
    tick();
    push_set(WB, 8'd2);
    tick();
    act_in_valid  = 1'b0;
    act_out_ready = 1'b1;
    tick();
    chk_out("pre_rst_u1", 1'b1, WA, 1'b0, 2'd2, 1'b0);
    #2;
    arst_n_in = 1'b0;
    #1;
    chk_out("rst_immediate", 1'b0, '0, 1'b0, 2'd0, 1'b1);
    tick();
    chk_out("rst_held", 1'b0, '0, 1'b0, 2'd0, 1'b1);
    arst_n_in = 1'b1;
    push_set(WE, 8'd2);
    tick();
    act_in_valid = 1'b0;
    chk_out("post_rst_e_u0", 1'b1, WE, 1'b0, 2'd1, 1'b1);
    tick();
    chk_out("post_rst_e_u1", 1'b1, WE, 1'b1, 2'd1, 1'b1);
    tick();
    chk_out("post_rst_empty", 1'b0, '0, 1'b0, 2'd0, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/activation_reuse_buffer.md
# activation_reuse_buffer

Two-entry activation buffer that sits directly downstream of the activation byte-reordering driver and feeds the PE array's activation broadcast bus. It accepts one lane-ordered activation word per handshake and presents each word to the PE array a programmable number of times (activation reuse across output-channel groups). Decoupled valid/ready handshakes on both sides absorb SRAM read latency and PE stalls.

## Interface
- IO_DATA_WIDTH, 8, bits per activation lane
- MEM_BW, 128, SRAM word width; LANES = MEM_BW/IO_DATA_WIDTH (derived, 16 by default)
- CNT_WIDTH, 8, width of the reuse counter
- clk  input  1  single clock, all state on rising edge
- arst_n_in  input  1  asynchronous active-low reset
- act_in  input  LANES*IO_DATA_WIDTH  lane-ordered word from the activation driver
- act_in_valid  input  1  act_in holds a valid word
- act_in_ready  output  1  buffer can accept a word this cycle
- reuse_count  input  CNT_WIDTH  presentations for the word on act_in; sampled with it
- flush  input  1  synchronous clear of all buffered state
- act_out  output  LANES*IO_DATA_WIDTH  head word to the PE array
- act_out_valid  output  1  act_out is valid
- act_out_ready  input  1  PE array consumes act_out this cycle
- act_out_last  output  1  current presentation is the final one for the head word
- occupancy  output  2  number of stored words (0..2)

## Operation
- Storage: two entries {data, reuse}, write pointer, read pointer (1 bit each), occupancy counter, use counter (CNT_WIDTH bits).
- Push: act_in_valid && act_in_ready stores act_in and reuse_count at write pointer; write pointer toggles.
- reuse_count = 0 is stored as 1 (word presented once, never dropped).
- act_in_ready = (occupancy != 2); no combinational path from act_out_ready to act_in_ready.
- act_out / act_out_valid: driven from head entry when occupancy > 0; act_out = 0 and act_out_valid = 0 when empty.
- act_out_last = act_out_valid && (use counter == head reuse − 1).
- Output handshake (act_out_valid && act_out_ready): if act_out_last, pop the head (read pointer toggles, use counter ← 0); else use counter increments.
- Simultaneous push and pop: occupancy unchanged; allowed at occupancy 1; at occupancy 2 the push is blocked by act_in_ready = 0 even if a pop occurs.
- Push while empty: word is not visible on act_out until the next cycle.
- flush: occupancy, both pointers and use counter cleared next edge; a push or pop in the flush cycle is discarded; stored data need not be cleared.
- act_out must hold stable while act_out_valid && !act_out_ready.
- Pointer wrap is natural 1-bit toggle; use counter never exceeds reuse − 1.

## Timing
- Reset (arst_n_in = 0, asynchronous): occupancy = 0, pointers = 0, use counter = 0; hence act_out_valid = 0, act_out = 0, act_out_last = 0, act_in_ready = 1, occupancy = 0 immediately and throughout reset.
- Reset mid-operation discards all buffered words and partial reuse progress.
- Latency act_in accept → act_out_valid: 1 cycle.
- Throughput: one word per cycle sustained when every reuse = 1 and act_out_ready held high; a word with reuse N occupies the head for N output handshakes.
- All outputs are functions of registered state only (act_out_last additionally of registered reuse); no input-to-output combinational path.

## Test plan
- Reset then push word 0x0F0E…0100 with reuse 1, act_out_ready = 1 -> act_out_valid next cycle with same data, act_out_last = 1, popped after one handshake, occupancy 1 → 0.
- Push A (reuse 3) and B (reuse 2), act_out_ready = 1 -> act_out shows A three cycles (last on third), then B two cycles (last on second); act_in_ready = 0 while occupancy = 2.
- Fill both entries, hold act_out_ready = 0 for 5 cycles -> act_out stable on A, act_in_ready = 0, occupancy = 2; release -> normal drain.
- reuse_count = 0 on a push -> word presented exactly once with act_out_last = 1.
- Assert flush with occupancy 2 and use counter 1, act_in_valid = 1 same cycle -> next cycle occupancy 0, act_out_valid = 0, act_in_ready = 1, pushed word lost.
- Drive arst_n_in low mid-reuse with occupancy 2 -> outputs go to reset values immediately; after release, a fresh push with reuse 2 presents exactly twice.
